// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO behind the UART receiver: stores each frame with its
// parity/framing flags, flags overruns and counts accepted errored frames.
module uart_rx_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_parity_err,
    input  logic                     rx_frame_err,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_parity_err,
    output logic                     rd_frame_err,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    input  logic                     clr_overrun,
    output logic [7:0]               err_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = DATA_W + 2;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW-1:0] AfC    = CW'(AF_LEVEL);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    err_count_q, err_count_d;

    logic          push, pop, drop;
    logic [EW-1:0] head;

    // A full FIFO still accepts a frame when the host pops in the same cycle.
    always_comb begin
        push = rx_valid && (!full || rd_en);
        pop  = rd_en && !empty;
        drop = rx_valid && full && !rd_en;
    end

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        overrun_d   = overrun_q;
        err_count_d = err_count_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (push && (rx_parity_err || rx_frame_err) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            err_count_q <= err_count_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {rx_frame_err, rx_parity_err, rx_data};
        end
    end

    always_comb begin
        head          = mem_q[rd_ptr_q];
        empty         = (count_q == '0);
        full          = (count_q == DepthC);
        almost_full   = (count_q >= AfC);
        count         = count_q;
        overrun       = overrun_q;
        err_count     = err_count_q;
        rd_data       = empty ? '0 : head[DATA_W-1:0];
        rd_parity_err = empty ? 1'b0 : head[DATA_W];
        rd_frame_err  = empty ? 1'b0 : head[DATA_W+1];
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid, rx_parity_err, rx_frame_err, rd_en, clr_overrun;
    logic [7:0] rx_data;
    logic [7:0] rd_data;
    logic       rd_parity_err, rd_frame_err, empty, full, almost_full, overrun;
    logic [4:0] count;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of {frame_err, parity_err, data}.
    logic [9:0] mq[$];
    logic       m_ovr;
    int         m_err;

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8), .AF_LEVEL(AF)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_parity_err(rd_parity_err),
        .rd_frame_err (rd_frame_err),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .count        (count),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    wire [26:0] dut_vec = {rd_frame_err, rd_parity_err, rd_data, empty, full, almost_full,
                           count, overrun, err_count};

    function automatic logic [26:0] exp_vec();
        logic [9:0] h;
        int         n;
        n = mq.size();
        h = (n > 0) ? mq[0] : 10'd0;
        return {h[9], h[8], h[7:0], (n == 0), (n == DEPTH), (n >= AF), 5'(n), m_ovr, 8'(m_err)};
    endfunction

    // One clock of stimulus; the model advances using the pre-edge state.
    task automatic step(input logic v, input logic [7:0] d, input logic pe, input logic fe,
                        input logic rd, input logic clr);
        bit do_push, do_pop, do_drop;
        rx_valid = v; rx_data = d; rx_parity_err = pe; rx_frame_err = fe;
        rd_en = rd; clr_overrun = clr;
        do_pop  = rd && (mq.size() > 0);
        do_push = v && ((mq.size() < DEPTH) || rd);
        do_drop = v && (mq.size() == DEPTH) && !rd;
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back({fe, pe, d});
            if (pe || fe) m_err = (m_err < 255) ? m_err + 1 : 255;
        end
        if (do_drop) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        #1;
        rx_valid = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
        rx_parity_err = 1'b0; rx_frame_err = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovr = 1'b0;
        m_err = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        model_reset();
        n_checks++;
        if (dut_vec !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state got %h expected %h", dut_vec,
                     {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        step(1, 8'hA5, 0, 0, 0, 0);
        step(1, 8'h3C, 0, 0, 0, 0);
        n_checks++;
        if (count !== 5'd2 || empty !== 1'b0 || rd_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_two_pushes got count=%0d empty=%b data=%h expected 2 0 a5",
                     count, empty, rd_data);
        end
        step(0, 8'h00, 0, 0, 1, 0);
        n_checks++;
        if (count !== 5'd1 || rd_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL basic_pop1 got count=%0d data=%h expected 1 3c", count, rd_data);
        end
        step(0, 8'h00, 0, 0, 1, 0);
        n_checks++;
        if (empty !== 1'b1 || rd_data !== 8'h00 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL basic_pop2 got empty=%b data=%h count=%0d expected 1 00 0",
                     empty, rd_data, count);
        end
        step(0, 8'h00, 0, 0, 1, 0);
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL pop_while_empty got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 8'(i), 0, 0, 0, 0);
            n_checks++;
            if (almost_full !== (i + 1 >= AF) || full !== (i == DEPTH - 1)) begin
                n_fail++;
                $display("FAIL fill_flags push=%0d got af=%b full=%b expected af=%b full=%b",
                         i + 1, almost_full, full, (i + 1 >= AF), (i == DEPTH - 1));
            end
        end
        step(1, 8'hFF, 0, 0, 0, 0);
        n_checks++;
        if (overrun !== 1'b1 || count !== 5'd16 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL overrun_drop got ovr=%b count=%0d head=%h expected 1 16 00",
                     overrun, count, rd_data);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (rd_data !== 8'(i)) begin
                n_fail++;
                $display("FAIL drain_order idx=%0d got %h expected %h", i, rd_data, 8'(i));
            end
            step(0, 8'h00, 0, 0, 1, 0);
        end
        n_checks++;
        if (empty !== 1'b1 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_end got empty=%b ovr=%b expected 1 1", empty, overrun);
        end
        step(0, 8'h00, 0, 0, 0, 1);
    endtask

    task automatic test_full_simul();
        logic [7:0] last;
        for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom), 0, 0, 0, 0);
        step(1, 8'h55, 0, 0, 1, 0);
        n_checks++;
        if (count !== 5'd16 || overrun !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL full_push_pop got count=%0d ovr=%b vec=%h expected 16 0 vec=%h",
                     count, overrun, dut_vec, exp_vec());
        end
        last = 8'h00;
        while (!empty && mq.size() > 0) begin
            last = rd_data;
            step(0, 8'h00, 0, 0, 1, 0);
        end
        n_checks++;
        if (last !== 8'h55 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL full_simul_last got %h empty=%b expected 55 1", last, empty);
        end
    endtask

    task automatic test_err_flags();
        int base;
        base = m_err;
        step(1, 8'h11, 1, 0, 0, 0);
        step(1, 8'h22, 0, 1, 0, 0);
        n_checks++;
        if (err_count !== 8'(base + 2) || rd_parity_err !== 1'b1 || rd_frame_err !== 1'b0
            || rd_data !== 8'h11) begin
            n_fail++;
            $display("FAIL err_head got err=%0d pe=%b fe=%b data=%h expected %0d 1 0 11",
                     err_count, rd_parity_err, rd_frame_err, rd_data, base + 2);
        end
        step(0, 8'h00, 0, 0, 1, 0);
        n_checks++;
        if (rd_parity_err !== 1'b0 || rd_frame_err !== 1'b1 || rd_data !== 8'h22) begin
            n_fail++;
            $display("FAIL err_second got pe=%b fe=%b data=%h expected 0 1 22",
                     rd_parity_err, rd_frame_err, rd_data);
        end
        step(0, 8'h00, 0, 0, 1, 0);
    endtask

    task automatic test_wrap_and_clear();
        int op;
        step(1, 8'($urandom), 0, 0, 0, 0);
        step(1, 8'($urandom), 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            op = (mq.size() <= 1) ? 0 : (mq.size() >= 3) ? 1 : int'($urandom_range(0, 2));
            step(op != 1, 8'($urandom), 0, 0, op != 0, 0);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL wrap cyc=%0d got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        while (mq.size() < DEPTH) step(1, 8'($urandom), 0, 0, 0, 0);
        step(1, 8'hEE, 0, 0, 0, 1);
        n_checks++;
        if (overrun !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL ovr_set_wins got %b expected 1", overrun);
        end
        step(0, 8'h00, 0, 0, 0, 1);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear got %b expected 0", overrun);
        end
        while (mq.size() > 0) step(0, 8'h00, 0, 0, 1, 0);
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 300; i++) begin
            step(1, 8'($urandom), 1'($urandom), 1'b1, mq.size() > 0, 0);
        end
        n_checks++;
        if (err_count !== 8'd255 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL err_saturate got %0d expected 255", err_count);
        end
        while (mq.size() > 0) step(0, 8'h00, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        bit v, rd;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 99) < ((i % 100) < 50 ? 70 : 30));
            rd = ($urandom_range(0, 99) < ((i % 100) < 50 ? 30 : 70));
            step(v, 8'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 rd, ($urandom_range(0, 15) == 0));
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), 1, 0, 0, 0);
        while (!m_ovr) step(1, 8'($urandom), 0, 0, 0, 0);
        while (mq.size() > 5) step(0, 8'h00, 0, 0, 1, 0);
        n_checks++;
        if (count !== 5'd5 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset got count=%0d ovr=%b expected 5 1", count, overrun);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || overrun !== 1'b0 || err_count !== 8'd0
            || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset got count=%0d empty=%b ovr=%b err=%0d data=%h",
                     count, empty, overrun, err_count, rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1, 8'h77, 0, 0, 0, 0);
        n_checks++;
        if (rd_data !== 8'h77 || count !== 5'd1) begin
            n_fail++;
            $display("FAIL post_reset_push got %h count=%0d expected 77 1", rd_data, count);
        end
    endtask

    initial begin
        rx_valid = 1'b0; rx_data = 8'h00; rx_parity_err = 1'b0; rx_frame_err = 1'b0;
        rd_en = 1'b0; clr_overrun = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_fill_overrun();
        test_full_simul();
        test_err_flags();
        test_wrap_and_clear();
        test_random();
        while (mq.size() > 0) step(0, 8'h00, 0, 0, 1, 0);
        test_err_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
